// File: rtl/matcalc_pkg.sv
// Shared defaults and state encoding for the matrix add/subtract front end.
// Pure declarations; no logic.
package matcalc_pkg;

  localparam int DEF_ELEM_W = 4;
  localparam int DEF_N_ELEM = 16;
  localparam int DEF_WD_MAX = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_CLEAR,
    ST_LAUNCH,
    ST_WAIT,
    ST_DONE
  } loader_state_t;

endpackage

// File: rtl/mat_entry_counter.sv
// Up-counter with enable, priority clear and wrap flag.
// Wrap is asserted combinationally on the enabled cycle where cnt equals MAX.
module mat_entry_counter
  import matcalc_pkg::*;
#(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign wrap = en & (cnt == MAX_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mat_input_loader.sv
// Loads operands A then B over valid/ready, pulses path_rst then add_en, waits for finish.
// in_ready is the only combinational output; abort drops in_ready in the same cycle.
module mat_input_loader
  import matcalc_pkg::*;
#(
  parameter int ELEM_W = DEF_ELEM_W,
  parameter int N_ELEM = DEF_N_ELEM,
  parameter int WD_MAX = DEF_WD_MAX
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     op_sub,
  input  logic                     in_valid,
  input  logic [ELEM_W-1:0]        in_data,
  output logic                     in_ready,
  output logic [ELEM_W*N_ELEM-1:0] mat_A,
  output logic [ELEM_W*N_ELEM-1:0] mat_B,
  output logic                     sign,
  output logic                     path_rst,
  output logic                     add_en,
  input  logic                     finish,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int CNT_W = 4;

  loader_state_t    state;
  logic [CNT_W-1:0] idx;
  logic             idx_wrap;
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_wrap;
  logic             in_load;
  logic             start_ok;
  logic             beat;
  logic             wd_en;
  logic             wd_clr;

  assign in_load  = (state == ST_LOAD_A) || (state == ST_LOAD_B);
  assign in_ready = in_load & ~abort;
  assign beat     = in_valid & in_ready;
  assign start_ok = start & ((state == ST_IDLE) || (state == ST_DONE));
  assign wd_clr   = (state == ST_LAUNCH);
  assign wd_en    = (state == ST_WAIT) & ~finish;

  mat_entry_counter #(
    .W   (CNT_W),
    .MAX (N_ELEM - 1)
  ) u_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (beat),
    .clr   (start_ok),
    .cnt   (idx),
    .wrap  (idx_wrap)
  );

  // Wraps one short of WD_MAX so the expiring WAIT cycle is the one where the count reaches WD_MAX.
  mat_entry_counter #(
    .W   (CNT_W),
    .MAX (WD_MAX - 1)
  ) u_wd (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (wd_en),
    .clr   (wd_clr),
    .cnt   (wd_cnt),
    .wrap  (wd_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      mat_A    <= '0;
      mat_B    <= '0;
      sign     <= 1'b0;
      path_rst <= 1'b0;
      add_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      path_rst <= 1'b0;
      add_en   <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_LOAD_A;
            sign  <= op_sub;
            busy  <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
          end
        end
        ST_LOAD_A: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (beat) begin
            // Entry 0 lands in the MSB nibble so the add path sees row-major order.
            for (int i = 0; i < N_ELEM; i++) begin
              if (idx == CNT_W'(i)) mat_A[(N_ELEM-1-i)*ELEM_W +: ELEM_W] <= in_data;
            end
            if (idx_wrap) state <= ST_LOAD_B;
          end
        end
        ST_LOAD_B: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (beat) begin
            for (int i = 0; i < N_ELEM; i++) begin
              if (idx == CNT_W'(i)) mat_B[(N_ELEM-1-i)*ELEM_W +: ELEM_W] <= in_data;
            end
            if (idx_wrap) begin
              state    <= ST_CLEAR;
              path_rst <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          state  <= ST_LAUNCH;
          add_en <= 1'b1;
        end
        ST_LAUNCH: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (finish) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (wd_wrap) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mat_input_loader.sv
// Randomized bench for mat_input_loader against an array-based operand model.
module tb_mat_input_loader;

  localparam int ELEM_W = 4;
  localparam int N_ELEM = 16;
  localparam int WD_MAX = 15;
  localparam int NOM_LAT = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        op_sub = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_data = 4'h0;
  logic        finish = 1'b0;
  logic        in_ready;
  logic [63:0] mat_A;
  logic [63:0] mat_B;
  logic        sign;
  logic        path_rst;
  logic        add_en;
  logic        busy;
  logic        done;
  logic        err;

  int n_chk = 0;
  int n_pass = 0;

  logic [3:0] ea [16];
  logic [3:0] eb [16];
  logic [3:0] va [32];

  mat_input_loader #(
    .ELEM_W (ELEM_W),
    .N_ELEM (N_ELEM),
    .WD_MAX (WD_MAX)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .op_sub   (op_sub),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mat_A    (mat_A),
    .mat_B    (mat_B),
    .sign     (sign),
    .path_rst (path_rst),
    .add_en   (add_en),
    .finish   (finish),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] pack(input logic [3:0] e [16]);
    logic [63:0] r = 64'h0;
    for (int i = 0; i < 16; i++) r = (r << 4) | 64'(e[i]);
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_err"}, 64'(err), 0);
    chk({tag, "_path_rst"}, 64'(path_rst), 0);
    chk({tag, "_add_en"}, 64'(add_en), 0);
    chk({tag, "_sign"}, 64'(sign), 0);
    chk({tag, "_in_ready"}, 64'(in_ready), 0);
    chk({tag, "_mat_A"}, mat_A, 0);
    chk({tag, "_mat_B"}, mat_B, 0);
  endtask

  task automatic rand_vals();
    for (int i = 0; i < 32; i++) va[i] = 4'($urandom_range(0, 15));
  endtask

  // vmode: 0 valid always, 1 valid toggling starting low, 2 random valid.
  task automatic run_op(input bit sub, input int vmode, input int abort_at, input bit wd, input int rst_at);
    int acc;
    int lc;
    int done_k;
    bit v;
    start = 1'b1;
    op_sub = sub;
    cyc();
    start = 1'b0;
    op_sub = ~sub;
    chk("start_busy", 64'(busy), 1);
    chk("start_done_clr", 64'(done), 0);
    chk("start_err_clr", 64'(err), 0);
    chk("start_sign", 64'(sign), 64'(sub));
    acc = 0;
    lc = 0;
    while (acc < 32) begin
      if (lc >= 2000) begin
        chk("load_bound", 64'(acc), 32);
        in_valid = 1'b0;
        return;
      end
      case (vmode)
        0: v = 1'b1;
        1: v = lc[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data = va[acc];
      if (acc == abort_at) begin
        abort = 1'b1;
        #1 chk("abort_ready_low", 64'(in_ready), 0);
        cyc();
        abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_busy", 64'(busy), 0);
        #1 chk("abort_in_ready", 64'(in_ready), 0);
        for (int j = 0; j < 4; j++) begin
          cyc();
          chk("abort_no_path_rst", 64'(path_rst), 0);
          chk("abort_no_add_en", 64'(add_en), 0);
        end
        chk("abort_mat_A", mat_A, pack(ea));
        chk("abort_mat_B", mat_B, pack(eb));
        return;
      end
      #1 chk("load_ready", 64'(in_ready), 1);
      cyc();
      lc++;
      if (v) begin
        if (acc < 16) ea[acc] = va[acc];
        else eb[acc-16] = va[acc];
        acc++;
      end
    end
    in_valid = 1'b0;
    if (vmode == 0) chk("load_cycles", 64'(lc), 32);
    if (vmode == 1) chk("load_cycles_bp", 64'(lc), 64);
    chk("clear_path_rst", 64'(path_rst), 1);
    chk("clear_add_en", 64'(add_en), 0);
    chk("clear_busy", 64'(busy), 1);
    cyc();
    chk("launch_add_en", 64'(add_en), 1);
    chk("launch_path_rst", 64'(path_rst), 0);
    chk("launch_mat_A", mat_A, pack(ea));
    chk("launch_mat_B", mat_B, pack(eb));
    done_k = wd ? WD_MAX + 1 : NOM_LAT + 1;
    for (int k = 1; k <= done_k + 1; k++) begin
      cyc();
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
          ea[i] = 4'h0;
          eb[i] = 4'h0;
        end
        check_all_zero("rst_mid");
        #3 rst_n = 1'b1;
        cyc();
        chk("rst_idle_busy", 64'(busy), 0);
        chk("rst_idle_ready", 64'(in_ready), 0);
        return;
      end
      chk("wait_add_en", 64'(add_en), 0);
      chk("wait_done", 64'(done), 64'(k >= done_k));
      chk("wait_err", 64'(err), 64'(wd && (k >= done_k)));
      chk("wait_busy", 64'(busy), 64'(k < done_k));
      if (!wd && k == NOM_LAT) finish = 1'b1;
    end
    finish = 1'b0;
    cyc();
    chk("done_hold", 64'(done), 1);
    chk("done_sign", 64'(sign), 64'(sub));
    chk("done_mat_A", mat_A, pack(ea));
    chk("done_mat_B", mat_B, pack(eb));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ea[i] = 4'h0;
      eb[i] = 4'h0;
    end
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    cyc();

    // Beats offered in IDLE must be ignored.
    in_valid = 1'b1;
    in_data = 4'hA;
    for (int j = 0; j < 3; j++) begin
      #1 chk("idle_ready", 64'(in_ready), 0);
      cyc();
    end
    in_valid = 1'b0;
    chk("idle_mat_A", mat_A, 0);

    for (int i = 0; i < 16; i++) begin
      va[i] = 4'(i + 1);
      va[16+i] = 4'h1;
    end
    run_op(1'b0, 0, -1, 1'b0, -1);
    chk("add_mat_A_const", mat_A, 64'h123456789ABCDEF0);
    chk("add_mat_B_const", mat_B, 64'h1111111111111111);

    rand_vals();
    run_op(1'b0, 1, -1, 1'b0, -1);

    rand_vals();
    run_op(1'b0, 0, 16 + 7, 1'b0, -1);
    rand_vals();
    run_op(1'b0, 2, -1, 1'b0, -1);

    rand_vals();
    run_op(1'b1, 2, -1, 1'b0, -1);

    rand_vals();
    run_op(1'b0, 0, -1, 1'b1, -1);

    rand_vals();
    run_op(1'b1, 0, -1, 1'b1, 5);
    rand_vals();
    run_op(1'b0, 2, -1, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mat_input_loader.md
# mat_input_loader

Front-end stage for the matrix add/subtract path. Accepts 4-bit matrix entries one at a time over a valid/ready handshake and assembles two 16-entry operand matrices, A then B. It then clears and launches the downstream add path (`Add_Path`), waits for its `finish`, and reports completion. It owns operation select (add/subtract) and supervises the add path with a watchdog.

## Interface
Parameters:
- `ELEM_W`, 4, bits per matrix entry
- `N_ELEM`, 16, entries per matrix
- `WD_MAX`, 15, max cycles from `add_en` to `finish` before error

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset; one clock, reset asynchronous and active-low
- `start`  in  1  begin a new load; honoured in IDLE and DONE only
- `abort`  in  1  cancel load; honoured in LOAD_A/LOAD_B only
- `op_sub`  in  1  0 = add, 1 = subtract; sampled on accepted `start`
- `in_valid`  in  1  entry present on `in_data`
- `in_data`  in  ELEM_W  entry value
- `in_ready`  out  1  loader accepts an entry this cycle
- `mat_A`  out  ELEM_W*N_ELEM  operand A to add path
- `mat_B`  out  ELEM_W*N_ELEM  operand B to add path
- `sign`  out  1  operation to add path (1 = subtract)
- `path_rst`  out  1  synchronous active-high reset pulse to add path
- `add_en`  out  1  launch pulse to add path
- `finish`  in  1  completion level from add path
- `busy`  out  1  high in every state except IDLE and DONE
- `done`  out  1  result valid; held in DONE
- `err`  out  1  watchdog expired; held in DONE

## Operation
- States: IDLE, LOAD_A, LOAD_B, CLEAR, LAUNCH, WAIT, DONE.
- IDLE/DONE, `start`=1:
  - go to LOAD_A, index := 0, `sign` := `op_sub`.
  - `done` and `err` clear on leaving DONE.
- LOAD_A/LOAD_B:
  - `in_ready` = ~`abort`.
  - Accepted beat (`in_valid & in_ready`) writes entry `idx` to bits [63−4·idx −: 4]. Entry 0 is the MSB nibble, row-major, matching the add path's element order.
  - `idx` increments per accepted beat. The accepted beat at idx=15 wraps idx to 0 and moves LOAD_A→LOAD_B or LOAD_B→CLEAR.
- `abort` in LOAD_A/LOAD_B:
  - Go to IDLE; the beat in that cycle is not accepted.
  - Matrix registers keep their partially written contents.
- CLEAR: `path_rst`=1 for exactly 1 cycle → LAUNCH.
- LAUNCH: `add_en`=1 for exactly 1 cycle, watchdog counter := 0 → WAIT.
- WAIT:
  - `finish`=1 → DONE with `err`=0.
  - Otherwise the counter increments; when counter reaches `WD_MAX` → DONE with `err`=1.
- `mat_A`, `mat_B` and `sign` are stable from entry to CLEAR until the next accepted `start`. The add path reads them combinationally.
- Ignored inputs:
  - `in_valid` outside the load states.
  - `start` outside IDLE/DONE.
  - `abort` outside the load states.

## Timing
- Reset (async assert, synchronous deassert at the consumer):
  - State = IDLE.
  - All outputs 0, including `mat_A`, `mat_B`, `sign` and idx.
- All outputs are registered except `in_ready`, which is combinational from state and `abort`.
- `start` accepted at edge t → `in_ready`=1 from cycle t+1.
- Minimum load is 32 cycles with `in_valid` held high.
- The 32nd accepted beat at edge t →
  - `path_rst` high during cycle t+1
  - `add_en` high during cycle t+2
  - WAIT from t+3
- Nominal add path: `finish` rises 9 cycles after the `add_en` cycle. `done` rises the cycle after `finish` is seen.
- Reset mid-operation: immediate return to IDLE; pulses are truncated.

## Structure
- Shared package `matcalc_pkg` holds:
  - `ELEM_W`, `N_ELEM`, `WD_MAX` defaults
  - `loader_state_t` enum (7 states)
- One sub-module: `mat_entry_counter`, a 4-bit index with enable, clear and wrap flag, reused for the watchdog count.

## Test plan
- **Add:** `op_sub`=0; A beats 1,2,…,F,0; B beats all 1.
  - `mat_A`=64'h123456789ABCDEF0, `mat_B`=64'h1111111111111111, `sign`=0.
  - `path_rst` 1 cycle, then `add_en` 1 cycle; `finish` model at +9 → `done`=1, `err`=0.
- **Backpressure:** `in_valid` toggled 1/0 every cycle.
  - Exactly 32 accepted beats, 64 cycles of loading; entries land in order.
  - Beats offered in IDLE are dropped.
- **Abort:** `abort` after 7 B beats.
  - IDLE next cycle, `in_ready`=0, no `path_rst`/`add_en`.
  - Next `start` restarts at A entry 0.
- **Subtract and latch:** `op_sub`=1 at `start`, then `op_sub`=0 during load → `sign` stays 1 through DONE.
- **Watchdog:** `finish` tied 0 → DONE with `err`=1, `done`=1 exactly `WD_MAX`+1 cycles after the `add_en` cycle.
- **Reset:** `rst_n` pulsed low mid-WAIT → all outputs 0 before the next clock edge; state IDLE.
